// File: rtl/monopix_ro_sched_if.sv
// Pad-side and DAQ-side signal bundle for the MONOPIX readout scheduler.
// The slave modport is the scheduler; the master is the chip/FIFO side.
interface monopix_ro_sched_if #(
   parameter int unsigned WORD_W = 27
);
   logic [3:0]        en;
   logic [3:0]        token;
   logic [3:0]        data_in;
   logic [3:0]        freeze;
   logic [3:0]        read;
   logic [WORD_W-1:0] data_out;
   logic [1:0]        data_flav;
   logic              data_valid;
   logic              data_ready;
   logic              busy;
   logic [15:0]       word_cnt;

   modport slave (
      input  en, token, data_in, data_ready,
      output freeze, read, data_out, data_flav, data_valid, busy, word_cnt
   );

   modport master (
      output en, token, data_in, data_ready,
      input  freeze, read, data_out, data_flav, data_valid, busy, word_cnt
   );
endinterface

// File: rtl/monopix_ro_sched.sv
// Shared readout scheduler: round-robin TOKEN arbitration over four MONOPIX
// flavours, FREEZE/READ pad sequencing and serial capture of the hit word.
module monopix_ro_sched #(
   parameter int unsigned FREEZE_CYC = 3,
   parameter int unsigned READ_CYC   = 2,
   parameter int unsigned DATA_DLY   = 2,
   parameter int unsigned WORD_W     = 27,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic              clk_bx,
   input  logic              reset,
   monopix_ro_sched_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FRZ,
      ST_RD,
      ST_WT,
      ST_SH,
      ST_OUT
   } state_t;

   state_t            r_state, w_state;
   logic [1:0]        r_sel, w_sel;
   logic [1:0]        r_rr, w_rr;
   logic [7:0]        r_burst, w_burst;
   logic [4:0]        r_cnt, w_cnt;
   logic [WORD_W-2:0] r_sreg, w_sreg;
   logic [3:0]        r_freeze, w_freeze;
   logic [3:0]        r_read, w_read;
   logic [WORD_W-1:0] r_dout, w_dout;
   logic [1:0]        r_flav, w_flav;
   logic              r_valid, w_valid;
   logic [15:0]       r_word_cnt, w_word_cnt;

   logic [3:0]        w_req;
   logic [1:0]        w_gnt;
   logic [1:0]        w_idx;
   logic              w_found;
   logic [WORD_W-1:0] w_shift;

   assign w_req   = bus.token & bus.en;
   assign w_shift = {r_sreg, bus.data_in[r_sel]};

   always_comb begin
      w_found = 1'b0;
      w_gnt   = r_rr;
      w_idx   = r_rr;
      for (int unsigned i = 0; i < 4; i++) begin
         w_idx = r_rr + 2'(i);
         if (!w_found && w_req[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   always_comb begin
      w_state    = r_state;
      w_sel      = r_sel;
      w_rr       = r_rr;
      w_burst    = r_burst;
      w_cnt      = r_cnt;
      w_sreg     = r_sreg;
      w_freeze   = r_freeze;
      w_read     = r_read;
      w_dout     = r_dout;
      w_flav     = r_flav;
      w_valid    = r_valid;
      w_word_cnt = r_word_cnt;

      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_sel    = w_gnt;
               w_burst  = '0;
               w_cnt    = '0;
               w_freeze = 4'b0001 << w_gnt;
               w_state  = ST_FRZ;
            end
         end
         ST_FRZ: begin
            if (r_cnt == 5'(FREEZE_CYC - 1)) begin
               w_cnt   = '0;
               w_read  = r_freeze;
               w_state = ST_RD;
            end else begin
               w_cnt = r_cnt + 5'd1;
            end
         end
         ST_RD: begin
            if (r_cnt == 5'(READ_CYC - 1)) begin
               w_cnt   = '0;
               w_read  = '0;
               w_state = (DATA_DLY == 0) ? ST_SH : ST_WT;
            end else begin
               w_cnt = r_cnt + 5'd1;
            end
         end
         ST_WT: begin
            if (r_cnt == 5'(DATA_DLY - 1)) begin
               w_cnt   = '0;
               w_state = ST_SH;
            end else begin
               w_cnt = r_cnt + 5'd1;
            end
         end
         ST_SH: begin
            w_sreg = w_shift[WORD_W-2:0];
            if (r_cnt == 5'(WORD_W - 1)) begin
               w_cnt   = '0;
               w_dout  = w_shift;
               w_flav  = r_sel;
               w_valid = 1'b1;
               w_state = ST_OUT;
            end else begin
               w_cnt = r_cnt + 5'd1;
            end
         end
         ST_OUT: begin
            if (bus.data_ready) begin
               w_valid = 1'b0;
               w_burst = r_burst + 8'd1;
               if (r_word_cnt != 16'hFFFF) w_word_cnt = r_word_cnt + 16'd1;
               // burst+1 compared in 9 bits so MAX_BURST=255 cannot wrap
               if (w_req[r_sel] && (({1'b0, r_burst} + 9'd1) < 9'(MAX_BURST))) begin
                  w_cnt   = '0;
                  w_read  = r_freeze;
                  w_state = ST_RD;
               end else begin
                  w_freeze = '0;
                  w_rr     = r_sel + 2'd1;
                  w_state  = ST_IDLE;
               end
            end
         end
         default: w_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_bx) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_rr       <= '0;
         r_burst    <= '0;
         r_cnt      <= '0;
         r_sreg     <= '0;
         r_freeze   <= '0;
         r_read     <= '0;
         r_dout     <= '0;
         r_flav     <= '0;
         r_valid    <= 1'b0;
         r_word_cnt <= '0;
      end else begin
         r_state    <= w_state;
         r_sel      <= w_sel;
         r_rr       <= w_rr;
         r_burst    <= w_burst;
         r_cnt      <= w_cnt;
         r_sreg     <= w_sreg;
         r_freeze   <= w_freeze;
         r_read     <= w_read;
         r_dout     <= w_dout;
         r_flav     <= w_flav;
         r_valid    <= w_valid;
         r_word_cnt <= w_word_cnt;
      end
   end

   assign bus.freeze     = r_freeze;
   assign bus.read       = r_read;
   assign bus.data_out   = r_dout;
   assign bus.data_flav  = r_flav;
   assign bus.data_valid = r_valid;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_monopix_ro_sched.sv
// Bench for monopix_ro_sched: behavioural chip model serialises words after each
// READ, a scoreboard queue holds expected words, pad protocol is checked each cycle.
module tb_monopix_ro_sched;

   localparam int unsigned FREEZE_CYC = 3;
   localparam int unsigned READ_CYC   = 2;
   localparam int unsigned DATA_DLY   = 2;
   localparam int unsigned WORD_W     = 27;
   localparam int unsigned MAX_BURST  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   monopix_ro_sched_if #(.WORD_W(WORD_W)) bus ();

   monopix_ro_sched #(
      .FREEZE_CYC(FREEZE_CYC),
      .READ_CYC  (READ_CYC),
      .DATA_DLY  (DATA_DLY),
      .WORD_W    (WORD_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk_bx(clk),
      .reset (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // chip / consumer model state
   int          pending [4] = '{0, 0, 0, 0};
   logic [26:0] exp_word [$];
   int          exp_flav [$];
   int          grant_q [$];
   int          hs_cnt = 0;
   int          cyc = 0;
   logic        ser_active = 1'b0;
   int          ser_k = 0, ser_f = 0, ser_idx = -1;
   logic [26:0] ser_word = '0;
   logic        use_fixed = 1'b0;
   logic [26:0] fixed_word = '0;
   logic        rearm = 1'b0;
   logic        bp_arm = 1'b0, bp_active = 1'b0;
   int          bp_left = 0;
   logic [26:0] bp_word = '0;
   logic [15:0] bp_wc = '0;

   initial begin
      bus.en = 4'b1111;
      bus.token = '0;
      bus.data_in = '0;
      bus.data_ready = 1'b1;
   end

   // per-cycle monitor, chip model and scoreboard, all at negedge
   initial begin : mon
      logic [3:0] prv_frz, prv_rd, prv_req, fz, rd, din, tok;
      logic       prv_busy, rdy;
      int t_frz, t_rd, nreads, pend_g, gf, idx, expn;
      prv_frz = '0; prv_rd = '0; prv_req = '0; prv_busy = 1'b0;
      t_frz = 0; t_rd = 0; nreads = 0; pend_g = 0; gf = 0;
      forever begin
         @(negedge clk);
         cyc++;
         din = 4'($urandom);
         if (rst) begin
            prv_frz = '0; prv_rd = '0; prv_req = '0; prv_busy = 1'b0;
            ser_active = 1'b0; ser_idx = -1;
            exp_word.delete(); exp_flav.delete();
            hs_cnt = 0; bp_active = 1'b0;
            bus.data_in = din;
            bus.data_ready = 1'b1;
            for (int f = 0; f < 4; f++) tok[f] = (pending[f] != 0);
            bus.token = tok;
            continue;
         end
         fz = bus.freeze;
         rd = bus.read;

         chk("frz_onehot", 32'($countones(fz) <= 1), 1);
         chk("rd_eq_frz", 32'((rd == 0) || (rd == fz)), 1);
         chk("busy", 32'(bus.busy), 32'(fz != 0));
         chk("word_cnt", 32'(bus.word_cnt), 32'(hs_cnt));
         if (prv_frz != 0 && fz != 0) chk("frz_switch", 32'(fz), 32'(prv_frz));
         if (!prv_busy && prv_req != 0) chk("tok2frz", 32'(fz != 0), 1);

         if (prv_frz == 0 && fz != 0) begin
            gf = 0;
            for (int f = 0; f < 4; f++) if (fz[f]) gf = f;
            grant_q.push_back(gf);
            chk("frz_en", 32'(bus.en[gf]), 1);
            t_frz = cyc; nreads = 0; pend_g = pending[gf];
            if (rearm && gf == 1) pending[0] = 1;
         end
         if (prv_frz != 0 && fz == 0) begin
            expn = (pend_g < int'(MAX_BURST)) ? pend_g : int'(MAX_BURST);
            chk("burst_len", 32'(nreads), 32'(expn));
         end
         if (prv_rd == 0 && rd != 0) begin
            nreads++;
            if (nreads == 1) chk("frz2rd", 32'(cyc - t_frz), FREEZE_CYC);
            t_rd = cyc;
            if (pending[gf] > 0) pending[gf]--;
         end
         if (prv_rd != 0 && rd == 0) begin
            chk("rd_width", 32'(cyc - t_rd), READ_CYC);
            ser_active = 1'b1; ser_k = 0; ser_f = gf;
            ser_word = use_fixed ? fixed_word : 27'($urandom);
            use_fixed = 1'b0;
            exp_word.push_back(ser_word);
            exp_flav.push_back(gf);
         end

         if (ser_active) begin
            idx = ser_k - int'(DATA_DLY);
            ser_idx = idx;
            if (idx >= 0 && idx < 27) din[ser_f] = ser_word[26 - idx];
            if (idx >= 26) ser_active = 1'b0;
            ser_k++;
         end

         rdy = 1'b1;
         if (bus.data_valid) begin
            if (bp_arm && !bp_active) begin
               bp_active = 1'b1; bp_left = 40;
               bp_word = bus.data_out; bp_wc = bus.word_cnt;
            end
            if (bp_active) begin
               chk("bp_data", 32'(bus.data_out), 32'(bp_word));
               chk("bp_valid", 32'(bus.data_valid), 1);
               chk("bp_noread", 32'(rd), 0);
               chk("bp_wcnt", 32'(bus.word_cnt), 32'(bp_wc));
               if (bp_left > 0) begin
                  rdy = 1'b0; bp_left--;
               end else begin
                  bp_active = 1'b0; bp_arm = 1'b0;
               end
            end
            if (rdy) begin
               if (exp_word.size() == 0) begin
                  chk("sb_underflow", 1, 0);
               end else begin
                  chk("data_out", 32'(bus.data_out), 32'(exp_word.pop_front()));
                  chk("data_flav", 32'(bus.data_flav), 32'(exp_flav.pop_front()));
               end
               hs_cnt++;
            end
         end

         for (int f = 0; f < 4; f++) tok[f] = (pending[f] != 0);
         bus.token = tok;
         bus.data_in = din;
         bus.data_ready = rdy;
         prv_frz = fz; prv_rd = rd; prv_busy = bus.busy;
         prv_req = tok & bus.en;
      end
   end

   task automatic wait_idle(input int max_cyc);
      int n = 0, stable = 0;
      logic any;
      while (stable < 3 && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
         any = 1'b0;
         for (int f = 0; f < 4; f++) if (pending[f] != 0 && bus.en[f]) any = 1'b1;
         if (!bus.busy && !any && !ser_active && exp_word.size() == 0) stable++;
         else stable = 0;
      end
      if (n >= max_cyc) chk("timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_freeze", 32'(bus.freeze), 0);
      chk("rst_read", 32'(bus.read), 0);
      chk("rst_valid", 32'(bus.data_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_wcnt", 32'(bus.word_cnt), 0);
      chk("rst_dout", 32'(bus.data_out), 0);
      chk("rst_flav", 32'(bus.data_flav), 0);
      rst = 1'b0;
   endtask

   initial begin : main
      int n;
      do_reset();

      // round-robin: token[0] re-raised while flavour 1 is served must wait its turn
      grant_q.delete();
      rearm = 1'b1;
      pending = '{1, 1, 1, 1};
      wait_idle(2000);
      rearm = 1'b0;
      chk("rr_count", 32'(grant_q.size()), 5);
      for (int i = 0; i < 5; i++)
         if (i < grant_q.size()) chk("rr_order", 32'(grant_q[i]), 32'(i % 4));

      // single hit with the reference word
      do_reset();
      fixed_word = {6'd42, 6'd63, 6'd21, 9'd10};
      use_fixed = 1'b1;
      pending[0] = 1;
      wait_idle(500);
      chk("single_wcnt", 32'(bus.word_cnt), 1);

      // burst cap: 11 words on flavour 2 -> bursts of 8 and 3
      grant_q.delete();
      pending[2] = 11;
      wait_idle(3000);
      chk("cap_grants", 32'(grant_q.size()), 2);
      for (int i = 0; i < 2; i++)
         if (i < grant_q.size()) chk("cap_flav", 32'(grant_q[i]), 2);
      chk("cap_wcnt", 32'(bus.word_cnt), 12);

      // backpressure on flavour 3
      bp_arm = 1'b1;
      pending[3] = 2;
      wait_idle(1000);
      chk("bp_done", 32'(bp_arm | bp_active), 0);
      chk("bp_wcnt_end", 32'(bus.word_cnt), 14);

      // enable mask
      grant_q.delete();
      bus.en = 4'b1010;
      pending = '{1, 1, 1, 1};
      wait_idle(1000);
      chk("en_grants", 32'(grant_q.size()), 2);
      chk("en_left0", 32'(pending[0]), 1);
      chk("en_left2", 32'(pending[2]), 1);
      pending = '{0, 0, 0, 0};
      bus.en = 4'b1111;

      // reset mid-shift, with rr moved away from 0 beforehand
      do_reset();
      pending[1] = 1;
      wait_idle(500);
      pending[2] = 1;
      n = 0;
      while (!(ser_active && ser_idx == 13) && n < 500) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 500) chk("sh_timeout", 0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_freeze", 32'(bus.freeze), 0);
      chk("mid_read", 32'(bus.read), 0);
      chk("mid_valid", 32'(bus.data_valid), 0);
      chk("mid_wcnt", 32'(bus.word_cnt), 0);
      chk("mid_busy", 32'(bus.busy), 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_novalid", 32'(bus.data_valid), 0);
      grant_q.delete();
      pending[0] = 1;
      pending[2] = 1;
      wait_idle(1000);
      chk("mid_grants", 32'(grant_q.size()), 2);
      if (grant_q.size() > 0) chk("mid_rr0", 32'(grant_q[0]), 0);
      chk("mid_wcnt_end", 32'(bus.word_cnt), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/monopix_ro_sched.md
Name: monopix_ro_sched

Overview:
- Single-clock readout scheduler that shares one serial-capture engine between the four MONOPIX readout flavours: 0=PMOS_NOSF, 1=PMOS, 2=COMP, 3=HV.
- Arbitrates the chip TOKEN lines round-robin and drives the matching FREEZE/READ pads.
- Deserialises the 27-bit hit word {col[5:0], te[5:0], le[5:0], row[8:0]} from the selected OUT line.
- Presents each word with its flavour tag on a valid/ready stream to the DAQ FIFO.
- Sits between the chip pads and the readout FIFO, replacing four independent per-flavour controllers.

Parameters:
- FREEZE_CYC, 3, cycles FREEZE is held before the first READ of a burst (1..15).
- READ_CYC, 2, width of each READ pulse in cycles (1..15).
- DATA_DLY, 2, cycles from READ falling to the first sampled data bit (0..15).
- WORD_W, 27, serial word length; MSB (col[5]) arrives first.
- MAX_BURST, 8, maximum words read from one flavour before it must yield (1..255).

Ports:
- clk_bx  in  1  bunch-crossing clock; clocks all logic and sampling.
- reset  in  1  synchronous, active-high.
- en  in  4  per-flavour enable; a disabled flavour's token is ignored.
- token  in  4  chip TOKEN lines.
- data_in  in  4  chip OUT lines.
- freeze  out  4  FREEZE pads, one-hot or zero.
- read  out  4  READ pads, one-hot or zero.
- data_out  out  27  captured word.
- data_flav  out  2  flavour tag of data_out.
- data_valid  out  1  data_out/data_flav valid.
- data_ready  in  1  consumer accepts the word when valid&ready.
- busy  out  1  high in any state other than IDLE.
- word_cnt  out  16  total words delivered, saturating at 0xFFFF.

Behaviour:
- Reset values: freeze=0, read=0, data_out=0, data_flav=0, data_valid=0, busy=0, word_cnt=0. Internally: state=IDLE, round-robin pointer rr=0, burst=0.
- Reset asserted in any state aborts the operation on the next edge, with no partial word output. The chip then sees freeze/read fall together.
- req = token & en.
- IDLE:
  - If req!=0, grant the first set bit searching rr, rr+1, … mod 4.
  - Register sel, set burst=0, go to FRZ. freeze[sel] rises on the transition edge.
- FRZ: hold FREEZE_CYC cycles, then go to RD.
- RD:
  - read[sel]=1 for exactly READ_CYC cycles, then go to WT.
  - freeze[sel] stays high through RD, WT, SH and OUT of the whole burst.
- WT: DATA_DLY cycles, then go to SH. With DATA_DLY=0, go directly to SH.
- SH:
  - Sample data_in[sel] on WORD_W consecutive edges.
  - Shift left: sreg <= {sreg[25:0], data_in[sel]}.
  - On the last edge, load data_out and data_flav=sel, set data_valid=1, go to OUT.
- OUT:
  - Hold data_out/data_flav/data_valid stable until data_ready=1. No timeout.
  - On the handshake cycle: data_valid drops next edge, word_cnt++ (saturating), burst++.
  - Next state:
    - If req[sel]=1 and burst+1<MAX_BURST, go to RD. This is a new READ with freeze kept high and no FRZ repeat.
    - Otherwise, drop freeze[sel], set rr=sel+1 mod 4, go to IDLE.
- Token dropping during FRZ/RD/WT/SH is ignored; the word is still captured.
- en[sel] deasserted mid-burst takes effect only at the OUT decision.
- Simultaneous tokens: granted strictly by rr order.
- One-idle-cycle rule: after a flavour yields, at least one IDLE cycle precedes the next grant, so freeze never switches flavour on a single edge.
- Latency:
  - token to freeze: 1 cycle.
  - freeze to first read rise: FREEZE_CYC.
  - read fall to first sample: DATA_DLY.
  - last sample to data_valid: same edge.
- Invariants: popcount(freeze)<=1; read!=0 implies read==freeze.

Test Plan:
- Single hit: token[0] high until first READ, data_in[0] serialises 0x2A_3F_15_00A (col=42 te=63 le=21 row=10), defaults, data_ready=1 -> freeze[0] rises 1 cycle after token, read[0] 2-cycle pulse 3 cycles later, data_valid with data_out={6'd42,6'd63,6'd21,9'd10}, data_flav=0, word_cnt=1, freeze falls.
- Burst cap: token[2] held high, MAX_BURST=8 -> exactly 8 READ pulses under one continuous freeze[2], 8 words tagged 2, then freeze drops and IDLE is entered.
- Round-robin: token=4'b1111 continuously, MAX_BURST=1 -> grant order 0,1,2,3,0 with one IDLE cycle between grants; freeze never two-hot.
- Backpressure: data_ready low for 40 cycles at OUT -> data_out/data_valid stable for all 40 cycles, no further READ, word_cnt increments once after ready.
- Enable mask: en=4'b1010, token=4'b1111 -> only flavours 1 and 3 are served; freeze[0]/freeze[2] stay 0.
- Reset mid-shift: reset asserted at bit 13 of SH -> next edge freeze=read=0, data_valid=0, word_cnt unchanged at 0 from a fresh start, rr=0.
